// File: rtl/rain_column_scheduler_pkg.sv
// Shared types and constants for the glyph-rain column scheduler.
package rain_column_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // Per-column animation state: 12 bits per column.
  typedef struct packed {
    logic [6:0] head;
    logic [1:0] acc;
    logic [1:0] speed;
    logic       lit;
  } col_t;

  localparam int              LFSR_W        = 16;
  // Fibonacci taps 16,14,13,11 expressed on a right-shifting register (bits 0,2,3,5).
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

  localparam int NUM_COLS_DEF = 80;
  localparam int HEAD_MAX_DEF = 55;

  // One LFSR step: feedback enters at the top, register shifts right.
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] v);
    return {^(v & LFSR_TAPS), v[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/rain_column_scheduler_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that advances only when step is high.
module rain_lfsr
  import rain_column_scheduler_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  // Shift register: reload the seed on reset, advance on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (step) begin
      value <= lfsr_advance(value);
    end
  end

endmodule

// File: rtl/rain_column_scheduler.sv
// Per-column glyph-rain scheduler: seeds every column after reset, then
// advances all columns once per accepted vsync edge and serves a registered
// read port to the pixel pipeline.
module rain_column_scheduler
  import rain_column_scheduler_pkg::*;
#(
  parameter int                NUM_COLS  = NUM_COLS_DEF,
  parameter int                HEAD_MAX  = HEAD_MAX_DEF,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause,
  input  logic [6:0] rd_col,
  output logic [6:0] rd_head,
  output logic [1:0] rd_speed,
  output logic       rd_lit,
  output logic [9:0] frame,
  output logic       warm,
  output logic       busy
);

  localparam int                IDX_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_COLS - 1);
  localparam logic [7:0]        RD_LIMIT = 8'(NUM_COLS);
  localparam logic [6:0]        HEAD_TOP = 7'(HEAD_MAX);

  col_t             cols [NUM_COLS];
  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] col_idx;
  logic [IDX_W-1:0] col_idx_next;
  logic             vsync_q;
  logic             vsync_edge;
  logic             frame_accept;
  logic             lfsr_step;
  logic [LFSR_W-1:0] lfsr;
  logic             wr_en;
  col_t             cur;
  col_t             col_wr;
  logic [2:0]       sum;
  logic             last_col;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;

  rain_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .value (lfsr)
  );

  assign vsync_edge   = vsync & ~vsync_q;
  assign frame_accept = (state == ST_IDLE) && vsync_edge && !pause;
  assign cur          = cols[col_idx];
  assign sum          = {1'b0, cur.acc} + {1'b0, cur.speed} + 3'd1;
  assign last_col     = (col_idx == LAST_IDX);
  assign busy         = (state != ST_IDLE);
  assign rd_valid     = ({1'b0, rd_col} < RD_LIMIT);
  assign rd_idx       = rd_col[IDX_W-1:0];

  // State, column pointer and vsync history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      col_idx <= '0;
      vsync_q <= 1'b1;
    end else begin
      state   <= state_next;
      col_idx <= col_idx_next;
      vsync_q <= vsync;
    end
  end

  // Next state and the column write for the column currently addressed.
  always_comb begin
    state_next   = state;
    col_idx_next = col_idx;
    lfsr_step    = 1'b0;
    wr_en        = 1'b0;
    col_wr       = cur;
    case (state)
      ST_INIT: begin
        lfsr_step    = 1'b1;
        wr_en        = 1'b1;
        col_wr.head  = {1'b0, lfsr[5:0]} & 7'h37;
        col_wr.speed = lfsr[7:6];
        col_wr.lit   = lfsr[8] | lfsr[9];
        col_wr.acc   = 2'd0;
        if (last_col) begin
          state_next   = ST_IDLE;
          col_idx_next = '0;
        end else begin
          col_idx_next = col_idx + 1'b1;
        end
      end
      ST_IDLE: begin
        col_idx_next = '0;
        if (vsync_edge) begin
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        lfsr_step = 1'b1;
        if (!pause) begin
          wr_en = 1'b1;
          if (sum[2]) begin
            if (cur.head == HEAD_TOP) begin
              // Column ran off the bottom: restart at the top with fresh traits.
              col_wr.head  = 7'd0;
              col_wr.acc   = 2'd0;
              col_wr.speed = lfsr[1:0];
              col_wr.lit   = lfsr[2] | lfsr[3];
            end else begin
              col_wr.head = cur.head + 7'd1;
              col_wr.acc  = sum[1:0];
            end
          end else begin
            col_wr.acc = sum[1:0];
          end
        end
        if (last_col) begin
          state_next   = ST_IDLE;
          col_idx_next = '0;
        end else begin
          col_idx_next = col_idx + 1'b1;
        end
      end
      default: begin
        state_next   = ST_INIT;
        col_idx_next = '0;
      end
    endcase
  end

  // Column state array; INIT rewrites every entry so no reset is needed here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      cols[col_idx] <= col_wr;
    end
  end

  // Frame counter and sticky wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= 10'd0;
      warm  <= 1'b0;
    end else if (frame_accept) begin
      frame <= frame + 10'd1;
      if (frame == 10'h3FF) begin
        warm <= 1'b1;
      end
    end
  end

  // Registered display read port; out-of-range columns read as blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_head  <= 7'd0;
      rd_speed <= 2'd0;
      rd_lit   <= 1'b0;
    end else if (rd_valid) begin
      rd_head  <= cols[rd_idx].head;
      rd_speed <= cols[rd_idx].speed;
      rd_lit   <= cols[rd_idx].lit && (state != ST_INIT);
    end else begin
      rd_head  <= 7'd0;
      rd_speed <= 2'd0;
      rd_lit   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rain_column_scheduler.sv
// Scoreboard bench: a behavioural model of every column predicts read-port
// contents, frame and warm; a small-column instance covers the frame wrap.
module tb_rain_column_scheduler;

  localparam int          NC   = 80;
  localparam int          NCS  = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk;
  logic       rst_n;
  logic       vsync, pause;
  logic [6:0] rd_col;
  logic [6:0] rd_head;
  logic [1:0] rd_speed;
  logic       rd_lit;
  logic [9:0] frame;
  logic       warm, busy;

  logic       vsync_s;
  logic [6:0] rd_col_s;
  logic [6:0] rd_head_s;
  logic [1:0] rd_speed_s;
  logic       rd_lit_s;
  logic [9:0] frame_s;
  logic       warm_s, busy_s;

  int checks = 0;
  int errors = 0;

  rain_column_scheduler dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .rd_col(rd_col),
    .rd_head(rd_head), .rd_speed(rd_speed), .rd_lit(rd_lit),
    .frame(frame), .warm(warm), .busy(busy)
  );

  rain_column_scheduler #(.NUM_COLS(NCS)) dut_s (
    .clk(clk), .rst_n(rst_n), .vsync(vsync_s), .pause(1'b0), .rd_col(rd_col_s),
    .rd_head(rd_head_s), .rd_speed(rd_speed_s), .rd_lit(rd_lit_s),
    .frame(frame_s), .warm(warm_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  int          m_head [NC];
  int          m_acc  [NC];
  int          m_speed[NC];
  int          m_lit  [NC];
  logic [15:0] m_lfsr;
  int          m_frame;
  int          m_warm;
  int          m_respawns = 0;

  typedef struct {
    int col;
    int exp_val;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    logic [15:0] fb;
    fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
    return (l >> 1) | (fb << 15);
  endfunction

  task automatic model_init();
    for (int c = 0; c < NC; c++) begin
      m_head[c]  = int'(m_lfsr[5:0]) & 'h37;
      m_speed[c] = int'(m_lfsr[7:6]);
      m_lit[c]   = (m_lfsr[8] || m_lfsr[9]) ? 1 : 0;
      m_acc[c]   = 0;
      m_lfsr     = lfsr_nx(m_lfsr);
    end
  endtask

  task automatic model_scan(input bit p);
    int s;
    for (int c = 0; c < NC; c++) begin
      if (!p) begin
        s = m_acc[c] + m_speed[c] + 1;
        if (s >= 4) begin
          if (m_head[c] == 55) begin
            m_head[c]  = 0;
            m_acc[c]   = 0;
            m_speed[c] = int'(m_lfsr[1:0]);
            m_lit[c]   = (m_lfsr[2] || m_lfsr[3]) ? 1 : 0;
            m_respawns++;
          end else begin
            m_head[c] = m_head[c] + 1;
            m_acc[c]  = s - 4;
          end
        end else begin
          m_acc[c] = s;
        end
      end
      m_lfsr = lfsr_nx(m_lfsr);
    end
  endtask

  function automatic int exp_of(input int c);
    if (c >= NC) return 0;
    return m_head[c] * 8 + m_speed[c] * 2 + m_lit[c];
  endfunction

  // Read every column plus two out-of-range indices through the scoreboard.
  task automatic sweep(input string name);
    rd_exp_t e;
    int col;
    for (int k = 0; k <= NC + 2; k++) begin
      @(posedge clk);
      #1;
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        check($sformatf("%s_col%0d", name, e.col), int'({rd_head, rd_speed, rd_lit}), e.exp_val);
      end
      if (k < NC + 2) begin
        col    = (k < NC) ? k : ((k == NC) ? 100 : 127);
        rd_col = 7'(col);
        e.col     = col;
        e.exp_val = exp_of(col);
        rd_q.push_back(e);
      end
    end
    $display("sweep %s frame=%0d respawns=%0d", name, m_frame, m_respawns);
  endtask

  // One vsync pulse on the main instance, measuring busy length.
  task automatic do_edge(input bit p, input bit extra);
    int cnt;
    int guard;
    pause = p;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    cnt = 0;
    guard = 0;
    while (busy && guard < 400) begin
      cnt++;
      if (extra && cnt == 20) vsync = 1'b1;
      if (extra && cnt == 22) vsync = 1'b0;
      @(negedge clk);
      guard++;
    end
    if (!p) begin
      if (m_frame == 1023) m_warm = 1;
      m_frame = (m_frame + 1) % 1024;
    end
    model_scan(p);
    check("busy_len", cnt, NC);
    check("frame", int'(frame), m_frame);
    check("warm", int'(warm), m_warm);
    $display("edge pause=%0d extra=%0d frame=%0d busy_cycles=%0d", p, extra, frame, cnt);
    pause = 1'b0;
  endtask

  // Reset (optionally in the middle of a scan) and wait for INIT to finish.
  task automatic do_reset(input bit mid);
    int cnt;
    int guard;
    int lit_col;
    if (mid) begin
      @(negedge clk) vsync = 1'b1;
      @(negedge clk) vsync = 1'b0;
      repeat (40) @(negedge clk);
    end
    lit_col = NC - 1;
    for (int c = NC - 1; c >= 45; c--) if (m_lit[c] == 1) lit_col = c;
    rd_col = 7'(lit_col);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 1);
    check("rst_frame", int'(frame), 0);
    check("rst_rd", int'({rd_head, rd_speed, rd_lit}), 0);
    rst_n   = 1'b1;
    m_lfsr  = SEED;
    m_frame = 0;
    m_warm  = 0;
    cnt = 0;
    guard = 0;
    while (busy && guard < 400) begin
      cnt++;
      if (cnt == 10) vsync = 1'b1;
      if (cnt == 12) vsync = 1'b0;
      if (cnt == 40) check("init_lit", int'(rd_lit), 0);
      @(negedge clk);
      guard++;
    end
    model_init();
    check("init_busy_len", cnt, NC);
    check("init_frame", int'(frame), 0);
    check("init_warm", int'(warm), 0);
    $display("reset mid_scan=%0d init_cycles=%0d", mid, cnt);
  endtask

  task automatic edge_small();
    int guard;
    @(negedge clk) vsync_s = 1'b1;
    @(negedge clk) vsync_s = 1'b0;
    guard = 0;
    while (busy_s && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("small_timeout", guard, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sf;
    int sw;
    rst_n    = 1'b1;
    vsync    = 1'b0;
    pause    = 1'b0;
    rd_col   = 7'd0;
    vsync_s  = 1'b0;
    rd_col_s = 7'd0;
    foreach (m_lit[c]) m_lit[c] = 0;

    do_reset(1'b0);

    // Directed read of column 0 from the seed value.
    @(negedge clk) rd_col = 7'd0;
    @(negedge clk);
    check("col0_head", int'(rd_head), 33);
    check("col0_speed", int'(rd_speed), 3);
    check("col0_lit", int'(rd_lit), 0);
    check("s_col0_head", int'(rd_head_s), 33);
    check("s_col0_speed", int'(rd_speed_s), 3);
    check("s_col0_lit", int'(rd_lit_s), 0);
    sweep("post_reset");

    do_edge(1'b0, 1'b0);
    @(negedge clk) rd_col = 7'd0;
    @(negedge clk);
    check("col0_head_f1", int'(rd_head), 34);
    sweep("frame1");

    for (int i = 0; i < 5; i++) do_edge(1'b1, 1'b0);
    sweep("paused");

    for (int i = 0; i < 40; i++) begin
      do_edge(1'b0, (i == 3));
      sweep($sformatf("run%0d", i));
    end

    do_reset(1'b1);
    sweep("mid_scan_reset");
    do_edge(1'b0, 1'b1);
    sweep("after_reset_edge");

    // Frame wrap on the small instance.
    sf = 0;
    sw = 0;
    for (int i = 1; i <= 1034; i++) begin
      edge_small();
      if (sf == 1023) sw = 1;
      sf = (sf + 1) % 1024;
      if (i == 1023 || i == 1024 || i == 1034) begin
        check($sformatf("wrap_frame_%0d", i), int'(frame_s), sf);
        check($sformatf("wrap_warm_%0d", i), int'(warm_s), sw);
      end
      if (i % 256 == 0) $display("small edge %0d frame=%0d warm=%0d", i, frame_s, warm_s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
